// File: rtl/riscorvo_mem_responder.sv
// Shared-RAM responder for the riscorvo fetch and data ports. Ready is a one-cycle pulse, *_WAIT+1 cycles after valid is sampled.
// Optional RISCORVO_MEM_BOUNDS_EN flags out-of-range addresses via bus_err_o. Requests wait in valid until ready.
module riscorvo_mem_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int INSTR_WAIT = 0,
  parameter int DATA_WAIT  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_instr_i,
  input  logic [31:0] addr_instr_i,
  output logic        ready_instr_o,
  output logic [31:0] data_instr_o,
  input  logic        valid_data_i,
  input  logic [31:0] addr_data_i,
  input  logic [31:0] write_data_i,
  input  logic        read_write_i,
  input  logic [3:0]  mask_data_i,
  output logic        ready_data_o,
  output logic [31:0] read_data_o,
  output logic        bus_err_o
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] IW_LD = (INSTR_WAIT > 0) ? 4'(INSTR_WAIT - 1) : 4'd0;
  localparam logic [3:0] DW_LD = (DATA_WAIT > 0) ? 4'(DATA_WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_i_st, r_d_st;
  logic [3:0]  r_i_cnt, r_d_cnt;
  logic [31:0] r_i_addr, r_d_addr, r_d_wdat;
  logic        r_d_rw;
  logic [3:0]  r_d_mask;
  logic        r_i_rdy, r_d_rdy;
  logic [31:0] r_i_dat, r_d_dat;
  logic        r_bus_err;
  logic [31:0] r_mem [MEM_WORDS];

  logic [31:0]   w_i_addr, w_d_addr, w_d_wdat;
  logic          w_d_rw;
  logic [3:0]    w_d_mask;
  logic [AW-1:0] w_i_idx, w_d_idx;
  logic          w_i_commit, w_d_commit;
  logic          w_i_oob, w_d_oob;
  logic          w_unused;

  // With zero wait states the access happens on the accepting edge, so use the live request fields.
  assign w_i_addr = (r_i_st == S_IDLE) ? addr_instr_i : r_i_addr;
  assign w_d_addr = (r_d_st == S_IDLE) ? addr_data_i  : r_d_addr;
  assign w_d_wdat = (r_d_st == S_IDLE) ? write_data_i : r_d_wdat;
  assign w_d_rw   = (r_d_st == S_IDLE) ? read_write_i : r_d_rw;
  assign w_d_mask = (r_d_st == S_IDLE) ? mask_data_i  : r_d_mask;
  assign w_i_idx  = w_i_addr[AW+1:2];
  assign w_d_idx  = w_d_addr[AW+1:2];

  assign w_i_commit = reset_n &&
                      ((r_i_st == S_IDLE && valid_instr_i && INSTR_WAIT == 0) ||
                       (r_i_st == S_WAIT && r_i_cnt == 4'd0));
  assign w_d_commit = reset_n &&
                      ((r_d_st == S_IDLE && valid_data_i && DATA_WAIT == 0) ||
                       (r_d_st == S_WAIT && r_d_cnt == 4'd0));

`ifdef RISCORVO_MEM_BOUNDS_EN
  assign w_i_oob = |w_i_addr[31:AW+2];
  assign w_d_oob = |w_d_addr[31:AW+2];
`else
  assign w_i_oob = 1'b0;
  assign w_d_oob = 1'b0;
`endif

  assign w_unused = ^{w_i_addr[1:0], w_d_addr[1:0], w_i_addr[31:AW+2], w_d_addr[31:AW+2]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i_st   <= S_IDLE;
      r_i_cnt  <= 4'd0;
      r_i_addr <= 32'd0;
      r_i_rdy  <= 1'b0;
      r_i_dat  <= 32'd0;
    end else begin
      r_i_rdy <= w_i_commit;
      if (w_i_commit) r_i_dat <= w_i_oob ? 32'hDEAD_BEEF : r_mem[w_i_idx];
      case (r_i_st)
        S_IDLE: if (valid_instr_i) begin
          r_i_addr <= addr_instr_i;
          r_i_cnt  <= IW_LD;
          r_i_st   <= (INSTR_WAIT > 0) ? S_WAIT : S_RESP;
        end
        S_WAIT: if (r_i_cnt == 4'd0) r_i_st <= S_RESP;
                else r_i_cnt <= r_i_cnt - 4'd1;
        S_RESP: r_i_st <= S_IDLE;
        default: r_i_st <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d_st   <= S_IDLE;
      r_d_cnt  <= 4'd0;
      r_d_addr <= 32'd0;
      r_d_wdat <= 32'd0;
      r_d_rw   <= 1'b0;
      r_d_mask <= 4'd0;
      r_d_rdy  <= 1'b0;
      r_d_dat  <= 32'd0;
    end else begin
      r_d_rdy <= w_d_commit;
      if (w_d_commit && !w_d_rw) r_d_dat <= w_d_oob ? 32'hDEAD_BEEF : r_mem[w_d_idx];
      case (r_d_st)
        S_IDLE: if (valid_data_i) begin
          r_d_addr <= addr_data_i;
          r_d_wdat <= write_data_i;
          r_d_rw   <= read_write_i;
          r_d_mask <= mask_data_i;
          r_d_cnt  <= DW_LD;
          r_d_st   <= (DATA_WAIT > 0) ? S_WAIT : S_RESP;
        end
        S_WAIT: if (r_d_cnt == 4'd0) r_d_st <= S_RESP;
                else r_d_cnt <= r_d_cnt - 4'd1;
        S_RESP: r_d_st <= S_IDLE;
        default: r_d_st <= S_IDLE;
      endcase
    end
  end

  // RAM is never cleared; a same-edge fetch of a word being written sees the old contents.
  always_ff @(posedge clk) begin
    if (w_d_commit && w_d_rw && !w_d_oob) begin
      for (int b = 0; b < 4; b++) begin
        if (w_d_mask[b]) r_mem[w_d_idx][8*b +: 8] <= w_d_wdat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_bus_err <= 1'b0;
    else if ((w_i_commit && w_i_oob) || (w_d_commit && w_d_oob)) r_bus_err <= 1'b1;
  end

  assign ready_instr_o = r_i_rdy;
  assign data_instr_o  = r_i_dat;
  assign ready_data_o  = r_d_rdy;
  assign read_data_o   = r_d_dat;
  assign bus_err_o     = r_bus_err;
endmodule

// File: tb/tb_riscorvo_mem_responder.sv
// Directed bench: instance a uses default waits, instance b uses DATA_WAIT=3 for the mid-wait reset case.
module tb_riscorvo_mem_responder;
  logic clk = 1'b0;
  logic rst_n, rst2_n;
  always #5 clk = ~clk;

  logic        a_vi, a_ri, a_vd, a_rw, a_rd_rdy, a_err;
  logic [31:0] a_ai, a_di, a_ad, a_wd, a_rd;
  logic [3:0]  a_m;
  logic        b_vi, b_ri, b_vd, b_rw, b_rd_rdy, b_err;
  logic [31:0] b_ai, b_di, b_ad, b_wd, b_rd;
  logic [3:0]  b_m;

  int n_cmp = 0;
  int n_err = 0;

  riscorvo_mem_responder #(.MEM_WORDS(1024), .INSTR_WAIT(0), .DATA_WAIT(1)) dut_a (
    .clk(clk), .reset_n(rst_n),
    .valid_instr_i(a_vi), .addr_instr_i(a_ai), .ready_instr_o(a_ri), .data_instr_o(a_di),
    .valid_data_i(a_vd), .addr_data_i(a_ad), .write_data_i(a_wd), .read_write_i(a_rw),
    .mask_data_i(a_m), .ready_data_o(a_rd_rdy), .read_data_o(a_rd), .bus_err_o(a_err));

  riscorvo_mem_responder #(.MEM_WORDS(1024), .INSTR_WAIT(0), .DATA_WAIT(3)) dut_b (
    .clk(clk), .reset_n(rst2_n),
    .valid_instr_i(b_vi), .addr_instr_i(b_ai), .ready_instr_o(b_ri), .data_instr_o(b_di),
    .valid_data_i(b_vd), .addr_data_i(b_ad), .write_data_i(b_wd), .read_write_i(b_rw),
    .mask_data_i(b_m), .ready_data_o(b_rd_rdy), .read_data_o(b_rd), .bus_err_o(b_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic data_req(input bit sel, input logic [31:0] addr, input logic [31:0] wd,
                          input logic rw, input logic [3:0] m,
                          output logic [31:0] rd, output int lat);
    int  c;
    bit  done;
    @(negedge clk);
    if (sel) begin b_vd = 1'b1; b_ad = addr; b_wd = wd; b_rw = rw; b_m = m; end
    else     begin a_vd = 1'b1; a_ad = addr; a_wd = wd; a_rw = rw; a_m = m; end
    lat = 99; rd = 32'd0; c = 0; done = 1'b0;
    while (!done && c < 20) begin
      @(posedge clk); #1; c++;
      if ((sel ? b_rd_rdy : a_rd_rdy) === 1'b1) begin
        lat = c; rd = sel ? b_rd : a_rd; done = 1'b1;
      end
    end
    if (sel) b_vd = 1'b0; else a_vd = 1'b0;
    @(posedge clk); #1;
    chk("data_ready_single_pulse", 32'(sel ? b_rd_rdy : a_rd_rdy), 32'd0);
  endtask

  task automatic fetch(input logic [31:0] addr, output logic [31:0] rd, output int lat);
    int c;
    bit done;
    @(negedge clk);
    a_vi = 1'b1; a_ai = addr;
    lat = 99; rd = 32'd0; c = 0; done = 1'b0;
    while (!done && c < 20) begin
      @(posedge clk); #1; c++;
      if (a_ri === 1'b1) begin lat = c; rd = a_di; done = 1'b1; end
    end
    a_vi = 1'b0;
    @(posedge clk); #1;
    chk("instr_ready_single_pulse", 32'(a_ri), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic [3:0]  pat;
    logic        seen;
    rst_n = 1'b0; rst2_n = 1'b0;
    a_vi = 0; a_ai = 0; a_vd = 0; a_ad = 0; a_wd = 0; a_rw = 0; a_m = 0;
    b_vi = 0; b_ai = 0; b_vd = 0; b_ad = 0; b_wd = 0; b_rw = 0; b_m = 0;
    #12;
    chk("rst_ready_instr", 32'(a_ri), 32'd0);
    chk("rst_ready_data", 32'(a_rd_rdy), 32'd0);
    chk("rst_data_instr", a_di, 32'd0);
    chk("rst_read_data", a_rd, 32'd0);
    chk("rst_bus_err", 32'(a_err), 32'd0);
    chk("rst_b_read_data", b_rd, 32'd0);
    @(negedge clk); rst_n = 1'b1; rst2_n = 1'b1;

    data_req(0, 32'h10, 32'h1234_5678, 1'b1, 4'hF, rd, lat);
    chk("wr10_latency", 32'(lat), 32'd2);
    data_req(0, 32'h10, 32'd0, 1'b0, 4'h0, rd, lat);
    chk("rd10_latency", 32'(lat), 32'd2);
    chk("rd10_data", rd, 32'h1234_5678);
    data_req(0, 32'h40, 32'h0, 1'b1, 4'hF, rd, lat);
    chk("write_keeps_read_data", rd, 32'h1234_5678);

    data_req(0, 32'h20, 32'hAABB_CCDD, 1'b1, 4'hF, rd, lat);
    data_req(0, 32'h20, 32'h1122_3344, 1'b1, 4'b0101, rd, lat);
    data_req(0, 32'h20, 32'd0, 1'b0, 4'h0, rd, lat);
    chk("mask0101_data", rd, 32'hAA22_CC44);
    data_req(0, 32'h20, 32'h9999_9999, 1'b1, 4'b0000, rd, lat);
    chk("mask0000_ready", 32'(lat), 32'd2);
    data_req(0, 32'h20, 32'd0, 1'b0, 4'h0, rd, lat);
    chk("mask0000_unchanged", rd, 32'hAA22_CC44);

    data_req(0, 32'h0, 32'h0000_0013, 1'b1, 4'hF, rd, lat);
    fetch(32'h0, rd, lat);
    chk("fetch0_latency", 32'(lat), 32'd1);
    chk("fetch0_data", rd, 32'h13);
    @(negedge clk); a_vi = 1'b1; a_ai = 32'h0; pat = 4'd0;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; pat[k] = a_ri; end
    a_vi = 1'b0;
    chk("fetch_cadence", 32'(pat), 32'h5);
    chk("fetch_cadence_data", a_di, 32'h13);

    @(negedge clk); a_vd = 1'b1; a_ad = 32'h40; a_wd = 32'hFFFF_FFFF; a_rw = 1'b1; a_m = 4'hF;
    @(posedge clk); #1;
    a_vi = 1'b1; a_ai = 32'h40;
    @(posedge clk); #1;
    chk("collide_ready_data", 32'(a_rd_rdy), 32'd1);
    chk("collide_ready_instr", 32'(a_ri), 32'd1);
    chk("collide_old_word", a_di, 32'h0);
    a_vd = 1'b0; a_vi = 1'b0;
    @(posedge clk); #1;
    fetch(32'h40, rd, lat);
    chk("collide_new_word", rd, 32'hFFFF_FFFF);

    data_req(0, 32'h0000_1000, 32'd0, 1'b0, 4'h0, rd, lat);
    chk("oob_latency", 32'(lat), 32'd2);
`ifdef RISCORVO_MEM_BOUNDS_EN
    chk("oob_read_data", rd, 32'hDEAD_BEEF);
    chk("oob_bus_err", 32'(a_err), 32'd1);
    data_req(0, 32'h10, 32'd0, 1'b0, 4'h0, rd, lat);
    chk("oob_bus_err_held", 32'(a_err), 32'd1);
`else
    chk("alias_read_data", rd, 32'h13);
    chk("alias_bus_err", 32'(a_err), 32'd0);
`endif

    data_req(1, 32'h30, 32'hCAFE_0001, 1'b1, 4'hF, rd, lat);
    chk("b_wr_latency", 32'(lat), 32'd4);
    @(negedge clk); b_vd = 1'b1; b_ad = 32'h30; b_wd = 32'h5; b_rw = 1'b1; b_m = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst2_n = 1'b0; b_vd = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; seen = seen | b_rd_rdy; end
    @(negedge clk); rst2_n = 1'b1;
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; seen = seen | b_rd_rdy; end
    chk("rst_midwait_no_ready", 32'(seen), 32'd0);
    data_req(1, 32'h30, 32'd0, 1'b0, 4'h0, rd, lat);
    chk("rst_midwait_rd_latency", 32'(lat), 32'd4);
    chk("rst_midwait_write_dropped", rd, 32'hCAFE_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
